// File: rtl/pipe_mem_stage_pkg.sv
// Shared definitions for the memory stage.
// Contents:
//   - ARCH_WIDTH / DATA_WIDTH: address and data widths.
//   - mem_state_e: FSM state encodings (2 bits).
//   - W_*: RV funct3 width codes.
//   - width_size / is_aligned: width decoding helpers.
package pipe_mem_stage_pkg;

  localparam int ARCH_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Access size from a width code. Unused codes (011/110/111) fall into
  // the word bucket, so they behave exactly like W.
  function automatic logic [1:0] width_size(input logic [2:0] w);
    logic [1:0] sz;
    case (w)
      W_B, W_BU: sz = SZ_BYTE;
      W_H, W_HU: sz = SZ_HALF;
      default:   sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_aligned(input logic [2:0] w, input logic [1:0] off);
    logic ok;
    case (width_size(w))
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/pipe_mem_stage_load_align.sv
// Load lane extract/extend (purely combinational).
// Ports:
//   rdata  in  32  raw bus read word
//   offset in  2   byte offset of the access inside the word
//   width  in  3   RV funct3 width code
//   data   out 32  selected lane, shifted down and sign/zero extended
module load_align
  import pipe_mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  width,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic        is_unsigned;

  always_comb begin
    shifted     = rdata >> {offset, 3'b000};
    is_unsigned = (width == W_BU) || (width == W_HU);
    data        = rdata;
    case (width_size(width))
      SZ_BYTE: data = is_unsigned ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = is_unsigned ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/pipe_mem_stage.sv
// Memory stage: turns one EX-side load/store into a single bus transaction.
// Ports:
//   clk, rst (async, active-low)
//   ex_data_mem_we/re/data_width/in, ex_alu_result, flush : request from EX
//   bus_req/we/addr/wdata/wstrb                         : bus request
//   bus_ack/rdata/err                                   : bus completion
//   mem_stall/valid/load_data/misalign/fault            : pipeline results
//   dbg_state                                           : current FSM state
//
// Handshake: an access is taken in IDLE when (re|we) & !flush & aligned;
// mem_stall rises combinationally in that cycle and stays high through REQ.
// In REQ, bus_req is held with constant fields until a single-cycle bus_ack,
// which also qualifies bus_rdata/bus_err. DONE lasts one cycle and carries
// the result (mem_valid pulse, stall low). Misaligned accesses never reach
// the bus: they pulse mem_valid+mem_misalign in the IDLE cycle itself.
module pipe_mem_stage
  import pipe_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_data_mem_we,
  input  logic        ex_data_mem_re,
  input  logic [2:0]  ex_data_mem_data_width,
  input  logic [31:0] ex_data_mem_in,
  input  logic [31:0] ex_alu_result,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        mem_stall,
  output logic        mem_valid,
  output logic [31:0] mem_load_data,
  output logic        mem_misalign,
  output logic        mem_fault,
  output logic [1:0]  dbg_state
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  width_q, width_d;
  logic        we_q, we_d;
  logic        kill_q, kill_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_any;
  logic        aligned;
  logic        accept;
  logic        misalign_now;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] aligned_load;

  load_align u_load_align (
    .rdata  (rdata_q),
    .offset (addr_q[1:0]),
    .width  (width_q),
    .data   (aligned_load)
  );

  // Store lane placement: narrow data is replicated across the word so the
  // strobe alone selects the target bytes.
  always_comb begin
    st_wdata = ex_data_mem_in;
    st_wstrb = 4'b1111;
    case (width_size(ex_data_mem_data_width))
      SZ_BYTE: begin
        st_wdata = {4{ex_data_mem_in[7:0]}};
        st_wstrb = 4'b0001 << ex_alu_result[1:0];
      end
      SZ_HALF: begin
        st_wdata = {2{ex_data_mem_in[15:0]}};
        st_wstrb = 4'b0011 << ex_alu_result[1:0];
      end
      default: begin
        st_wdata = ex_data_mem_in;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    req_any      = ex_data_mem_re | ex_data_mem_we;
    aligned      = is_aligned(ex_data_mem_data_width, ex_alu_result[1:0]);
    accept       = (state_q == ST_IDLE) && req_any && !flush && aligned;
    misalign_now = (state_q == ST_IDLE) && req_any && !flush && !aligned;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    width_d = width_q;
    we_d    = we_q;
    kill_d  = kill_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          addr_d  = ex_alu_result;
          width_d = ex_data_mem_data_width;
          // re and we together behave as a store.
          we_d    = ex_data_mem_we;
          wdata_d = ex_data_mem_we ? st_wdata : 32'h0;
          wstrb_d = ex_data_mem_we ? st_wstrb : 4'b0000;
          kill_d  = 1'b0;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      ST_REQ: begin
        // The bus cycle must finish; a flush only hides its result.
        if (flush) kill_d = 1'b1;
        if (bus_ack) begin
          state_d = ST_DONE;
          rdata_d = bus_rdata;
          err_d   = bus_err;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      width_q <= 3'b000;
      we_q    <= 1'b0;
      kill_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      width_q <= width_d;
      we_q    <= we_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus_req       = (state_q == ST_REQ);
    bus_we        = bus_req & we_q;
    bus_addr      = {addr_q[31:2], 2'b00};
    bus_wdata     = wdata_q;
    bus_wstrb     = wstrb_q;
    mem_stall     = accept || (state_q == ST_REQ);
    mem_misalign  = misalign_now;
    mem_valid     = misalign_now || ((state_q == ST_DONE) && !kill_q);
    mem_fault     = (state_q == ST_DONE) && !kill_q && err_q;
    mem_load_data = ((state_q == ST_DONE) && !kill_q && !we_q && !err_q)
                    ? aligned_load : 32'h0;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
module tb_pipe_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_data_mem_we;
  logic        ex_data_mem_re;
  logic [2:0]  ex_data_mem_data_width;
  logic [31:0] ex_data_mem_in;
  logic [31:0] ex_alu_result;
  logic        flush;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        mem_stall;
  logic        mem_valid;
  logic [31:0] mem_load_data;
  logic        mem_misalign;
  logic        mem_fault;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  // Expected result per access: {valid, fault, misalign, load_data}
  logic [34:0] exp_q[$];

  pipe_mem_stage dut (
    .clk                    (clk),
    .rst                    (rst),
    .ex_data_mem_we         (ex_data_mem_we),
    .ex_data_mem_re         (ex_data_mem_re),
    .ex_data_mem_data_width (ex_data_mem_data_width),
    .ex_data_mem_in         (ex_data_mem_in),
    .ex_alu_result          (ex_alu_result),
    .flush                  (flush),
    .bus_req                (bus_req),
    .bus_we                 (bus_we),
    .bus_addr               (bus_addr),
    .bus_wdata              (bus_wdata),
    .bus_wstrb              (bus_wstrb),
    .bus_ack                (bus_ack),
    .bus_rdata              (bus_rdata),
    .bus_err                (bus_err),
    .mem_stall              (mem_stall),
    .mem_valid              (mem_valid),
    .mem_load_data          (mem_load_data),
    .mem_misalign           (mem_misalign),
    .mem_fault              (mem_fault),
    .dbg_state              (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model
  function automatic int m_size(input logic [2:0] w);
    if (w == 3'b000 || w == 3'b100) return 0;
    if (w == 3'b001 || w == 3'b101) return 1;
    return 2;
  endfunction

  function automatic logic m_misaligned(input logic [2:0] w, input logic [31:0] a);
    int sz = m_size(w);
    if (sz == 1) return a[0];
    if (sz == 2) return (a[1:0] != 2'b00);
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [2:0] w, input logic [1:0] off);
    int o = int'(off);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*o +: 8];
    h = rd[8*o +: 16];
    case (m_size(w))
      0: return (w == 3'b100) ? {24'h0, b} : {{24{b[7]}}, b};
      1: return (w == 3'b101) ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic we, input logic [2:0] w, input logic [1:0] off);
    if (!we) return 4'b0000;
    case (m_size(w))
      0: return 4'b0001 << off;
      1: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] w, input logic [31:0] d);
    case (m_size(w))
      0: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      1: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  // driver: one complete access, with result checked from the scoreboard
  task automatic run_access(input string tag, input logic we, input logic re,
                            input logic [2:0] w, input logic [31:0] addr,
                            input logic [31:0] wd, input int ack_delay,
                            input logic [31:0] rd, input logic err,
                            input logic flush_req);
    logic        mis;
    logic        is_st;
    logic [34:0] e;
    logic [34:0] got;
    mis   = m_misaligned(w, addr);
    is_st = we;
    if (mis)            e = {1'b1, 1'b0, 1'b1, 32'h0};
    else if (flush_req) e = {1'b0, 1'b0, 1'b0, 32'h0};
    else if (err)       e = {1'b1, 1'b1, 1'b0, 32'h0};
    else if (is_st)     e = {1'b1, 1'b0, 1'b0, 32'h0};
    else                e = {1'b1, 1'b0, 1'b0, m_load(rd, w, addr[1:0])};
    exp_q.push_back(e);

    tick();
    ex_data_mem_we         = we;
    ex_data_mem_re         = re;
    ex_data_mem_data_width = w;
    ex_data_mem_in         = wd;
    ex_alu_result          = addr;
    flush                  = 1'b0;
    @(negedge clk);

    if (mis) begin
      check({tag, ".mis_bus_req"}, 64'(bus_req), 64'(0));
      check({tag, ".mis_stall"}, 64'(mem_stall), 64'(0));
      check({tag, ".queue"}, 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {mem_valid, mem_fault, mem_misalign, mem_load_data};
        check({tag, ".result"}, 64'(got), 64'(e));
      end
      tick();
      ex_data_mem_we = 1'b0;
      ex_data_mem_re = 1'b0;
      @(negedge clk);
      check({tag, ".mis_pulse_end"}, 64'({mem_valid, mem_misalign, bus_req}), 64'(0));
      return;
    end

    check({tag, ".accept_stall"}, 64'(mem_stall), 64'(1));
    tick();
    for (int k = 0; k <= ack_delay; k++) begin
      flush = (flush_req && k == 0);
      if (k == ack_delay) begin
        bus_ack   = 1'b1;
        bus_rdata = rd;
        bus_err   = err;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        bus_err   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      check({tag, ".req"}, 64'({bus_req, mem_stall, mem_valid}), 64'(3'b110));
      check({tag, ".addr"}, 64'(bus_addr), 64'({addr[31:2], 2'b00}));
      check({tag, ".we"}, 64'(bus_we), 64'(is_st));
      check({tag, ".wstrb"}, 64'(bus_wstrb), 64'(m_wstrb(is_st, w, addr[1:0])));
      if (is_st) check({tag, ".wdata"}, 64'(bus_wdata), 64'(m_wdata(w, wd)));
      tick();
    end
    bus_ack        = 1'b0;
    bus_err        = 1'b0;
    flush          = 1'b0;
    ex_data_mem_we = 1'b0;
    ex_data_mem_re = 1'b0;
    @(negedge clk);
    check({tag, ".done_stall"}, 64'({mem_stall, bus_req}), 64'(0));
    check({tag, ".queue"}, 64'(exp_q.size() > 0), 64'(1));
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {mem_valid, mem_fault, mem_misalign, mem_load_data};
      check({tag, ".result"}, 64'(got), 64'(e));
    end
    tick();
    @(negedge clk);
    check({tag, ".valid_single"}, 64'({mem_valid, mem_fault}), 64'(0));
  endtask

  initial begin
    rst                    = 1'b0;
    ex_data_mem_we         = 1'b0;
    ex_data_mem_re         = 1'b0;
    ex_data_mem_data_width = 3'b000;
    ex_data_mem_in         = 32'h0;
    ex_alu_result          = 32'h0;
    flush                  = 1'b0;
    bus_ack                = 1'b0;
    bus_rdata              = 32'h0;
    bus_err                = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("reset.ctrl", 64'({bus_req, bus_we, mem_valid, mem_misalign, mem_fault, mem_stall}), 64'(0));
    check("reset.bus_addr", 64'(bus_addr), 64'(0));
    check("reset.bus_wdata", 64'(bus_wdata), 64'(0));
    check("reset.bus_wstrb", 64'(bus_wstrb), 64'(0));
    check("reset.load_data", 64'(mem_load_data), 64'(0));
    check("reset.state", 64'(dbg_state), 64'(0));
    tick();
    rst = 1'b1;

    // directed accesses         tag         we    re    w       addr          wdata         dly rdata         err   flush
    run_access("lb_103",        1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0,        0, 32'h80AA_BBCC, 1'b0, 1'b0);
    run_access("sh_202",        1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0,        1'b0, 1'b0);
    run_access("lw_101_mis",    1'b0, 1'b1, 3'b010, 32'h0000_0101, 32'h0,        0, 32'h0,        1'b0, 1'b0);
    run_access("lhu_0_flush",   1'b0, 1'b1, 3'b101, 32'h0000_0000, 32'h0,        4, 32'h0000_8001, 1'b0, 1'b1);
    run_access("sw_err",        1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_access("lh_2",          1'b0, 1'b1, 3'b001, 32'h0000_0012, 32'h0,        2, 32'h8001_0000, 1'b0, 1'b0);
    run_access("lhu_2",         1'b0, 1'b1, 3'b101, 32'h0000_0012, 32'h0,        0, 32'h8001_0000, 1'b0, 1'b0);
    run_access("lbu_101",       1'b0, 1'b1, 3'b100, 32'h0000_0101, 32'h0,        1, 32'h0000_F500, 1'b0, 1'b0);
    run_access("lb_0_pos",      1'b0, 1'b1, 3'b000, 32'h0000_0300, 32'h0,        0, 32'h1111_117F, 1'b0, 1'b0);
    run_access("lw_104",        1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0,        3, 32'hCAFE_F00D, 1'b0, 1'b0);
    run_access("sb_3",          1'b1, 1'b0, 3'b000, 32'h0000_0003, 32'h7777_775A, 0, 32'h0,        1'b0, 1'b0);
    run_access("ld_w011",       1'b0, 1'b1, 3'b011, 32'h0000_0208, 32'h0,        0, 32'h8765_4321, 1'b0, 1'b0);
    run_access("ld_w110",       1'b0, 1'b1, 3'b110, 32'h0000_020C, 32'h0,        1, 32'h0BAD_C0DE, 1'b0, 1'b0);
    run_access("ld_w111_mis",   1'b0, 1'b1, 3'b111, 32'h0000_0102, 32'h0,        0, 32'h0,        1'b0, 1'b0);
    run_access("lh_1_mis",      1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0,        0, 32'h0,        1'b0, 1'b0);
    run_access("sh_3_mis",      1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0,        0, 32'h0,        1'b0, 1'b0);
    run_access("re_we_store",   1'b1, 1'b1, 3'b010, 32'h0000_0050, 32'h0102_0304, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_access("lb_err",        1'b0, 1'b1, 3'b000, 32'h0000_0061, 32'h0,        0, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // flush in IDLE blocks acceptance
    tick();
    ex_data_mem_re         = 1'b1;
    ex_data_mem_data_width = 3'b010;
    ex_alu_result          = 32'h0000_0080;
    flush                  = 1'b1;
    @(negedge clk);
    check("flush_idle.now", 64'({mem_stall, mem_valid, bus_req}), 64'(0));
    tick();
    ex_data_mem_re = 1'b0;
    flush          = 1'b0;
    @(negedge clk);
    check("flush_idle.next", 64'({bus_req, dbg_state}), 64'(0));

    // stray ack in IDLE is ignored
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    bus_err   = 1'b1;
    tick();
    bus_ack = 1'b0;
    bus_err = 1'b0;
    @(negedge clk);
    check("stray_ack", 64'({mem_valid, mem_fault, bus_req, dbg_state}), 64'(0));

    // reset in the middle of REQ
    tick();
    ex_data_mem_re         = 1'b1;
    ex_data_mem_data_width = 3'b010;
    ex_alu_result          = 32'h0000_0010;
    tick();
    ex_data_mem_re = 1'b0;
    @(negedge clk);
    check("rst_mid.req_before", 64'(bus_req), 64'(1));
    #2 rst = 1'b0;
    #1;
    check("rst_mid.bus_req_now", 64'(bus_req), 64'(0));
    check("rst_mid.state", 64'(dbg_state), 64'(0));
    tick();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    rst     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) bus_ack = 1'b1;
      else        bus_ack = 1'b0;
      @(negedge clk);
      check("rst_mid.after", 64'({mem_valid, bus_req, dbg_state}), 64'(0));
      tick();
    end
    bus_ack = 1'b0;

    // randomized aligned loads and stores
    for (int n = 0; n < 24; n++) begin
      logic [2:0]  w;
      logic [31:0] a;
      logic        st;
      case ($urandom_range(0, 4))
        0: w = 3'b000;
        1: w = 3'b001;
        2: w = 3'b010;
        3: w = 3'b100;
        default: w = 3'b101;
      endcase
      a = {$urandom_range(0, 32'h3FFF), 2'b00};
      if (m_size(w) == 0) a[1:0] = 2'($urandom_range(0, 3));
      if (m_size(w) == 1) a[1]   = 1'($urandom_range(0, 1));
      st = (w[2] == 1'b0) && ($urandom_range(0, 3) == 0);
      run_access("rand", st, !st, w, a, $urandom, $urandom_range(0, 3),
                 $urandom, 1'b0, 1'b0);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mem_stage.md
PIPE_MEM_STAGE -- requirements
Module: pipe_mem_stage

Interface
REQ-001 SHALL use ports: clk in 1 (clock, all state on rising edge); rst in 1 (asynchronous, active-low reset).
REQ-002 SHALL accept EX-side inputs, all stable while mem_stall=1:
- ex_data_mem_we in 1 (store request)
- ex_data_mem_re in 1 (load request)
- ex_data_mem_data_width in 3 (RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU)
- ex_data_mem_in in 32 (store data)
- ex_alu_result in 32 (byte address)
- flush in 1 (kill current op)
REQ-003 SHALL drive bus outputs:
- bus_req out 1
- bus_we out 1
- bus_addr out 32 (word-aligned, [1:0]=00)
- bus_wdata out 32 (lane-shifted)
- bus_wstrb out 4
REQ-004 SHALL take bus inputs: bus_ack in 1 (one-cycle completion); bus_rdata in 32 (valid with ack); bus_err in 1 (valid with ack).
REQ-005 SHALL drive pipeline outputs:
- mem_stall out 1 (hold upstream)
- mem_valid out 1 (one-cycle completion pulse)
- mem_load_data out 32 (extended load result)
- mem_misalign out 1 (pulse)
- mem_fault out 1 (pulse)

Function
REQ-006 SHALL implement FSM IDLE, REQ, DONE, encoded in 2 bits.
REQ-007 IDLE: if (re|we) and !flush and aligned, SHALL latch addr/wdata/wstrb/width/we, go to REQ, and assert mem_stall combinationally that cycle.
REQ-008 Alignment: B/BU always aligned; H/HU SHALL require addr[0]=0; W SHALL require addr[1:0]=00.
REQ-009 Misaligned access in IDLE SHALL issue no bus cycle, pulse mem_misalign and mem_valid for one cycle, and stay IDLE.
REQ-010 REQ: bus_req=1, bus fields held constant, mem_stall=1; on bus_ack SHALL capture bus_rdata/bus_err and go to DONE.
REQ-011 DONE: mem_valid=1 and mem_stall=0 for exactly one cycle; mem_fault=captured err; next state IDLE.
REQ-012 Minimum load/store latency SHALL be 3 cycles (accept, REQ with ack, DONE); each extra wait cycle adds one.
REQ-013 Store lanes SHALL be: B -> data[7:0] replicated to all lanes, wstrb=0001<<addr[1:0]; H -> data[15:0] replicated, wstrb=0011<<addr[1:0]; W -> wstrb=1111.
REQ-014 Loads SHALL have bus_wstrb=0000 and bus_we=0.
REQ-015 Load data SHALL be the selected lane shifted by addr[1:0], sign-extended for B/H and zero-extended for BU/HU.
REQ-016 mem_load_data SHALL be 0 for stores, faults and misaligns.
REQ-017 Width codes 011/110/111 SHALL be treated as W.
REQ-018 flush in IDLE SHALL block acceptance.
REQ-019 flush in REQ SHALL NOT drop bus_req (the transaction completes), but SHALL set a kill flag that suppresses mem_valid, mem_fault and mem_load_data (forced 0) in DONE.
REQ-020 re and we both asserted SHALL be treated as a store.
REQ-021 bus_ack outside REQ SHALL be ignored.

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE and clear the kill flag and latches; bus_req, bus_we, mem_valid, mem_misalign, mem_fault SHALL be 0; bus_addr, bus_wdata, mem_load_data SHALL be 0; bus_wstrb SHALL be 0000.
REQ-023 Reset mid-REQ SHALL abandon the transaction; bus_req SHALL be 0 while rst=0 and SHALL not reassert until a new access is accepted.

Structure
REQ-024 FSM state encodings and width codes SHALL live in the shared common include next to ARCH_WIDTH/DATA_WIDTH.
REQ-025 Lane extract/extend logic SHALL be one combinational sub-module, load_align.

Verification
REQ-026 LB at addr 0x103, rdata 0x80AA_BBCC, ack in REQ cycle 1 -> mem_load_data=0xFFFF_FF80 on the single mem_valid cycle.
REQ-027 SH at addr 0x202, data 0x1234_ABCD -> bus_addr=0x200, wstrb=1100, wdata=0xABCD_ABCD, bus_we=1.
REQ-028 LW at 0x101 -> mem_misalign=1 and mem_valid=1 for one cycle, bus_req never asserted.
REQ-029 LHU at 0x0, ack delayed 4 cycles, flush in REQ -> bus_req held until ack, then mem_valid=0 in DONE.
REQ-030 rst low mid-REQ -> bus_req=0 immediately; after release, IDLE with no spurious mem_valid.
REQ-031 SW with bus_err=1 on ack -> mem_fault=1 and mem_valid=1 for one cycle, mem_load_data=0.
